// File: rtl/student_tlul_mux.sv
// TL-UL 1:NUM address-decoding mux with one outstanding transaction.
// Each device owns a 64-byte window. Indices past NUM go to an internal error responder.
package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module student_tlul_mux_port (
  input  tlul_pkg::tl_h2d_t host,
  input  logic              a_sel,
  input  logic              d_sel,
  output tlul_pkg::tl_h2d_t dev
);
  always_comb begin
    dev           = host;
    dev.a_address = {26'h0, host.a_address[5:0]};
    dev.a_valid   = host.a_valid & a_sel;
    dev.d_ready   = host.d_ready & d_sel;
  end
endmodule

module student_tlul_mux #(
  parameter int NUM = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  tlul_pkg::tl_h2d_t            tl_host_i,
  output tlul_pkg::tl_d2h_t            tl_host_o,
  input  tlul_pkg::tl_d2h_t [NUM-1:0]  tl_device_o,
  output tlul_pkg::tl_h2d_t [NUM-1:0]  tl_device_i
);
  import tlul_pkg::*;

  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic {IDLE, BUSY} state_e;
  state_e state, state_nx;

  logic [IW-1:0]  sel_idx, lat_idx;
  logic           sel_err, lat_err, err_vld;
  logic [2:0]     err_op;
  logic [7:0]     err_src;
  logic [1:0]     err_size;
  logic           dev_a_ready, host_a_ready, accept, d_hs;
  tl_d2h_t        dev_rsp, host_rsp;
  logic [NUM-1:0] a_sel, d_sel;

  assign sel_err = (tl_host_i.a_address[31:6] >= 26'(NUM));
  assign sel_idx = tl_host_i.a_address[6 +: IW];

  // Loop compare instead of direct indexing keeps non-power-of-two NUM X-free.
  always_comb begin
    dev_a_ready = 1'b0;
    dev_rsp     = '0;
    for (int i = 0; i < NUM; i++) begin
      if (sel_idx == IW'(i)) dev_a_ready = tl_device_o[i].a_ready;
      if (lat_idx == IW'(i)) dev_rsp = tl_device_o[i];
    end
  end

  // The error responder is always ready, so out-of-range requests never stall.
  assign host_a_ready = (state == IDLE) & (sel_err | dev_a_ready);
  assign accept       = host_a_ready & tl_host_i.a_valid;

  always_comb begin
    host_rsp = '0;
    if (state == BUSY) begin
      if (lat_err) begin
        host_rsp.d_valid  = err_vld;
        host_rsp.d_opcode = err_op;
        host_rsp.d_source = err_src;
        host_rsp.d_size   = err_size;
        host_rsp.d_error  = 1'b1;
      end else begin
        host_rsp = dev_rsp;
      end
    end
    host_rsp.a_ready = host_a_ready;
  end

  assign tl_host_o = host_rsp;
  assign d_hs      = (state == BUSY) & host_rsp.d_valid & tl_host_i.d_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (d_hs)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_idx  <= '0;
      lat_err  <= 1'b0;
      err_vld  <= 1'b0;
      err_op   <= '0;
      err_src  <= '0;
      err_size <= '0;
    end else if (accept) begin
      lat_idx  <= sel_err ? '0 : sel_idx;
      lat_err  <= sel_err;
      err_vld  <= sel_err;
      err_op   <= (tl_host_i.a_opcode == Get) ? AccessAckData : AccessAck;
      err_src  <= tl_host_i.a_source;
      err_size <= tl_host_i.a_size;
    end else if (d_hs) begin
      err_vld  <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_port
    assign a_sel[g] = (state == IDLE) & ~rst_i & ~sel_err & (sel_idx == IW'(g));
    assign d_sel[g] = (state == BUSY) & ~lat_err & (lat_idx == IW'(g));

    student_tlul_mux_port u_port (
      .host  (tl_host_i),
      .a_sel (a_sel[g]),
      .d_sel (d_sel[g]),
      .dev   (tl_device_i[g])
    );
  end
endmodule

// File: tb/tb_student_tlul_mux.sv
// Bench for student_tlul_mux: register-style device models, a word-level
// reference memory, directed steps and a randomized transaction phase.
module tb_student_tlul_mux;
  import tlul_pkg::*;

  localparam int NUM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tl_h2d_t           host_h2d;
  tl_d2h_t           host_d2h;
  tl_d2h_t [NUM-1:0] dev_d2h;
  tl_h2d_t [NUM-1:0] dev_h2d;

  student_tlul_mux #(.NUM(NUM)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_host_i   (host_h2d),
    .tl_host_o   (host_d2h),
    .tl_device_o (dev_d2h),
    .tl_device_i (dev_h2d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit xchk_on = 1'b0;
  bit spur_en = 1'b0;

  // Device models: 16 words each; word 0 reads back word1 * word2.
  logic [31:0] dmem    [NUM][16];
  bit          dpend   [NUM];
  int          dcnt    [NUM];
  tl_d2h_t     drsp    [NUM];
  logic [31:0] ref_mem [NUM][16];

  // Values sampled at the falling edge, consumed after the next rising edge.
  tl_d2h_t           s_host;
  tl_h2d_t [NUM-1:0] s_dev;
  bit                s_hacc, s_hdhs;
  bit [NUM-1:0]      s_dacc, s_ddhs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dev_reset();
    for (int i = 0; i < NUM; i++) begin
      for (int w = 0; w < 16; w++) begin
        dmem[i][w]    = '0;
        ref_mem[i][w] = '0;
      end
      dpend[i]   = 1'b0;
      dcnt[i]    = 0;
      drsp[i]    = '0;
      dev_d2h[i] = '0;
    end
  endtask

  task automatic dev_update();
    for (int i = 0; i < NUM; i++) begin
      int w;
      if (s_ddhs[i]) dpend[i] = 1'b0;
      if (s_dacc[i]) begin
        w = int'(s_dev[i].a_address[5:2]);
        drsp[i]          = '0;
        drsp[i].d_source = s_dev[i].a_source;
        drsp[i].d_size   = s_dev[i].a_size;
        drsp[i].d_user   = 16'(i + 1);
        drsp[i].d_sink   = 1'($urandom);
        if (s_dev[i].a_opcode == Get) begin
          drsp[i].d_opcode = AccessAckData;
          drsp[i].d_data   = (w == 0) ? dmem[i][1] * dmem[i][2] : dmem[i][w];
        end else begin
          drsp[i].d_opcode = AccessAck;
          for (int b = 0; b < 4; b++)
            if (s_dev[i].a_mask[b]) dmem[i][w][8*b +: 8] = s_dev[i].a_data[8*b +: 8];
        end
        dpend[i] = 1'b1;
        dcnt[i]  = $urandom_range(0, 3);
      end
      dev_d2h[i] = '0;
      if (dpend[i]) begin
        if (dcnt[i] == 0) begin
          dev_d2h[i]         = drsp[i];
          dev_d2h[i].d_valid = 1'b1;
        end else begin
          dcnt[i]--;
        end
      end else if (spur_en && $urandom_range(0, 5) == 0) begin
        dev_d2h[i].d_valid  = 1'b1;
        dev_d2h[i].d_data   = $urandom;
        dev_d2h[i].d_source = 8'($urandom);
      end
      dev_d2h[i].a_ready = !dpend[i] && ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    s_host = host_d2h;
    s_dev  = dev_h2d;
    s_hacc = host_h2d.a_valid && host_d2h.a_ready;
    s_hdhs = host_d2h.d_valid && host_h2d.d_ready;
    for (int i = 0; i < NUM; i++) begin
      s_dacc[i] = dev_h2d[i].a_valid && dev_d2h[i].a_ready;
      s_ddhs[i] = dev_d2h[i].d_valid && dev_h2d[i].d_ready;
    end
    if (xchk_on)
      chk("x_check", {$isunknown(host_h2d), $isunknown(host_d2h),
                      $isunknown(dev_h2d), $isunknown(dev_d2h)}, 0);
    @(posedge clk);
    #1;
    dev_update();
  endtask

  // One host transaction; bp >= 0 holds d_ready low for bp valid cycles, bp < 0 randomizes it.
  task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input int bp,
                     output logic [31:0] rdata, output logic rerr);
    int dev, w, n, nv, lat;
    bit err;
    logic [7:0]  src;
    logic [31:0] exp_data, first_data;
    logic [2:0]  exp_op;
    dev = int'(addr >> 6);
    err = (dev >= NUM);
    w   = int'(addr[5:2]);
    src = 8'($urandom);
    exp_data = '0;
    exp_op   = (op == Get) ? AccessAckData : AccessAck;
    if (!err) begin
      if (op == Get)
        exp_data = (w == 0) ? ref_mem[dev][1] * ref_mem[dev][2] : ref_mem[dev][w];
      else
        for (int b = 0; b < 4; b++)
          if (mask[b]) ref_mem[dev][w][8*b +: 8] = wdata[8*b +: 8];
    end

    host_h2d           = '0;
    host_h2d.a_opcode  = op;
    host_h2d.a_size    = 2'd2;
    host_h2d.a_source  = src;
    host_h2d.a_address = addr;
    host_h2d.a_mask    = mask;
    host_h2d.a_data    = wdata;
    host_h2d.a_user    = 16'($urandom);
    host_h2d.a_valid   = 1'b1;
    host_h2d.d_ready   = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      cycle();
      n++;
    end while (!s_hacc && n < 60);
    chk("a_accept", s_hacc, 1);
    for (int i = 0; i < NUM; i++)
      chk("a_route", s_dev[i].a_valid, (!err && i == dev));
    if (!err) begin
      chk("a_offset", s_dev[dev].a_address, {26'h0, addr[5:0]});
      chk("a_data", s_dev[dev].a_data, wdata);
      chk("a_opcode", s_dev[dev].a_opcode, op);
    end

    // Keep a different request pending on the A channel while busy.
    host_h2d.a_address = 32'($urandom_range(0, NUM + 1)) << 6;
    host_h2d.a_opcode  = Get;
    lat = 0;
    nv  = 0;
    first_data = '0;
    while (lat < 60) begin
      host_h2d.d_ready = (bp >= 0) ? (nv >= bp) : 1'($urandom_range(0, 1));
      cycle();
      lat++;
      chk("busy_a_ready", s_host.a_ready, 0);
      for (int i = 0; i < NUM; i++) begin
        chk("busy_a_valid", s_dev[i].a_valid, 0);
        chk("d_ready_route", s_dev[i].d_ready, (!err && i == dev && host_h2d.d_ready));
      end
      if (s_host.d_valid) begin
        if (nv == 0) begin
          first_data = s_host.d_data;
          if (err) chk("err_latency", lat, 1);
        end else begin
          chk("d_stable", s_host.d_data, first_data);
        end
        nv++;
      end
      if (s_hdhs) break;
    end
    chk("d_handshake", s_hdhs, 1);
    chk("d_error", s_host.d_error, err);
    chk("d_opcode", s_host.d_opcode, exp_op);
    chk("d_source", s_host.d_source, src);
    chk("d_size", s_host.d_size, 2'd2);
    chk("d_data", s_host.d_data, exp_data);
    chk("d_user", s_host.d_user, err ? 16'h0 : 16'(dev + 1));
    if (bp > 0) chk("bp_valid_cycles", nv, bp + 1);
    rdata = s_host.d_data;
    rerr  = s_host.d_error;
    host_h2d.a_valid = 1'b0;
    host_h2d.d_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, d;
    logic        re;
    logic [3:0]  m;
    logic [2:0]  op;
    int          n, r;
    host_h2d = '0;
    dev_reset();
    host_h2d.a_valid = 1'b1;
    host_h2d.d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_d2h", host_d2h, '0);
    for (int i = 0; i < NUM; i++) begin
      chk("rst_a_valid", dev_h2d[i].a_valid, 0);
      chk("rst_d_ready", dev_h2d[i].d_ready, 0);
    end
    host_h2d = '0;
    rst      = 1'b0;
    xchk_on  = 1'b1;

    // Register writes, then read-back including the derived word 0.
    txn(PutFullData, 32'h04, 32'h1, 4'hf, -1, rd, re);
    chk("put04_err", re, 0);
    txn(PutFullData, 32'h08, 32'h2, 4'hf, -1, rd, re);
    txn(PutFullData, 32'h44, 32'h2, 4'hf, -1, rd, re);
    txn(PutFullData, 32'h48, 32'h2, 4'hf, -1, rd, re);
    chk("put48_err", re, 0);
    txn(Get, 32'h04, 32'h0, 4'hf, -1, rd, re);
    chk("get04", rd, 32'h1);
    txn(Get, 32'h44, 32'h0, 4'hf, -1, rd, re);
    chk("get44", rd, 32'h2);
    txn(Get, 32'h00, 32'h0, 4'hf, -1, rd, re);
    chk("get00", rd, 32'h2);
    txn(Get, 32'h40, 32'h0, 4'hf, -1, rd, re);
    chk("get40", rd, 32'h4);
    chk("get40_err", re, 0);

    // Out-of-range window goes to the error responder.
    txn(Get, 32'h80, 32'h0, 4'hf, -1, rd, re);
    chk("oor_err", re, 1);
    chk("oor_data", rd, 32'h0);
    txn(PutPartialData, 32'h3C4, 32'hdead, 4'h3, 2, rd, re);
    chk("oor_put_err", re, 1);

    // Backpressure: d_ready low for 5 valid cycles.
    txn(Get, 32'h04, 32'h0, 4'hf, 5, rd, re);
    chk("bp_data", rd, 32'h1);

    // Randomized traffic with spurious d_valid from idle devices.
    spur_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 2);
      op = (r == 0) ? Get : (r == 1) ? PutFullData : PutPartialData;
      a = (32'($urandom_range(0, NUM + 1)) << 6) | (32'($urandom_range(0, 15)) << 2);
      d = $urandom;
      m = (op == PutPartialData) ? 4'($urandom_range(1, 15)) : 4'hf;
      txn(op, a, d, m, (k % 4 == 0) ? int'($urandom_range(0, 4)) : -1, rd, re);
    end
    spur_en = 1'b0;

    // Reset while a response is being held off.
    host_h2d           = '0;
    host_h2d.a_opcode  = Get;
    host_h2d.a_size    = 2'd2;
    host_h2d.a_address = 32'h04;
    host_h2d.a_mask    = 4'hf;
    host_h2d.a_valid   = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!s_hacc && n < 60);
    chk("rst_txn_accept", s_hacc, 1);
    n = 0;
    do begin cycle(); n++; end while (!s_host.d_valid && n < 20);
    chk("rst_txn_busy", s_host.d_valid, 1);
    #2;
    rst = 1'b1;
    host_h2d.d_ready = 1'b1;
    #1;
    chk("rst_mid_d_valid", host_d2h.d_valid, 0);
    for (int i = 0; i < NUM; i++) begin
      chk("rst_mid_a_valid", dev_h2d[i].a_valid, 0);
      chk("rst_mid_d_ready", dev_h2d[i].d_ready, 0);
    end
    dev_reset();
    host_h2d = '0;
    repeat (2) cycle();
    rst = 1'b0;
    txn(Get, 32'h04, 32'h0, 4'hf, -1, rd, re);
    chk("post_rst_get04", rd, 32'h0);
    chk("post_rst_err", re, 0);

    repeat (2) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/student_tlul_mux.md
STUDENT_TLUL_MUX -- requirements
Module: student_tlul_mux

Interface
REQ-001 Parameter NUM, default 2: number of attached TL-UL devices (1..16).
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk_i  in  1  system clock, all state on rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 tl_host_i  in  tlul_pkg::tl_h2d_t  host request channel (A) plus d_ready.
REQ-006 tl_host_o  out  tlul_pkg::tl_d2h_t  host response channel (D) plus a_ready.
REQ-007 tl_device_o  in  tlul_pkg::tl_d2h_t [NUM]  responses from device i. The port name is fixed by existing instantiations despite its input direction.
REQ-008 tl_device_i  out  tlul_pkg::tl_h2d_t [NUM]  requests to device i. The port name is fixed by existing instantiations despite its output direction.

Function
REQ-009 Address map: each device owns a 64-byte window; device index = a_address[31:6].
REQ-010 Index >= NUM SHALL select an internal error responder.
REQ-011 Forwarded a_address SHALL be the offset a_address[5:0] zero-extended to 32 bits; all other A fields (opcode, param, size, source, mask, data, user) pass through unchanged to every device.
REQ-012 Only the selected device SHALL see a_valid = host a_valid, and only while the mux is idle; all other devices see a_valid = 0.
REQ-013 Host a_ready SHALL equal the selected device's a_ready while idle. It SHALL be 0 while a transaction is outstanding.
REQ-014 State: IDLE, BUSY. IDLE->BUSY on host a_valid & a_ready, latching the selected index (or the error flag). BUSY->IDLE on host d_valid & d_ready.
REQ-015 At most one outstanding transaction.
REQ-016 In BUSY, tl_host_o D fields SHALL be the latched device's D fields, combinationally.
REQ-017 d_ready SHALL go only to the latched device; all other devices see d_ready = 0.
REQ-018 In IDLE, host d_valid SHALL be 0 and all other D fields 0.
REQ-019 Error responder timing: d_valid asserted the cycle after acceptance, held until d_ready.
REQ-020 Error responder D fields: d_error = 1, d_data = 0, d_source and d_size echoed, d_opcode = AccessAckData for Get and AccessAck for PutFull/PartialData, d_param = d_sink = d_user = 0.
REQ-021 The A path adds zero cycles of latency. Device response latency passes through unchanged.
REQ-022 A device d_valid arriving while the mux is not BUSY on that device SHALL be ignored.
REQ-023 Host d_ready low SHALL hold BUSY and keep the response stable.
REQ-024 Simultaneous d handshake and new a_valid: the new request is accepted no earlier than the following cycle, in IDLE.
REQ-025 No output SHALL ever be X or Z after reset release. Unused fields are driven to 0 or pass-through.

Reset
REQ-026 rst_i asserted SHALL asynchronously force IDLE and latched index = 0, clear the error-pending flag, set host d_valid = 0 and all device a_valid/d_ready = 0.
REQ-027 Reset mid-transaction SHALL abandon the outstanding response; the first request after release is serviced normally.

Verification
REQ-028 Write path: put_word 0x04 <- 1, 0x08 <- 0x02, 0x44 <- 2, 0x48 <- 0x02 (regdemo devices) -> each write acked with d_error = 0, only the addressed device receives a_valid.
REQ-029 Read back: get_word 0x04 = 1, 0x44 = 2, 0x00 = 2 (SHIFTOUT), 0x40 = 4 -> exact values, d_error = 0.
REQ-030 Out-of-range: get_word 0x80 with NUM = 2 -> d_error = 1, d_data = 0, source echoed, one-cycle latency; no device sees a_valid.
REQ-031 Backpressure: host d_ready held low 5 cycles after a read -> d_valid and d_data stable, a_ready = 0 throughout, completion on the d_ready rise.
REQ-032 Reset mid-transaction: rst_i pulsed while BUSY -> host d_valid = 0 immediately; a subsequent read of 0x04 returns the device value (0 after device reset).
REQ-033 Continuous X check on all four channels from the first falling edge after reset release.
